// File: rtl/bg_pixel_resolver.sv
// Background pixel resolver: picks the frontmost visible layer word of each pixel,
// looks its colour up in BG palette RAM (or takes a bitmapped colour directly) and hands it on.
//
// state   | meaning
// COLLECT | accepting layer words, tracking the current winner
// READ    | palette read strobe for winner / backdrop index
// CAPTURE | palette data returning, latch colour
// DONE    | resolved pixel offered to the compositor
module bg_pixel_resolver #(
    parameter int MAX_LAYERS     = 4,
    parameter int BACKDROP_INDEX = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        px_valid,
    output logic        px_ready,
    input  logic [19:0] px_data,
    input  logic        px_last,
    output logic        pal_re,
    output logic [7:0]  pal_addr,
    input  logic [14:0] pal_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] out_color,
    output logic [2:0]  out_bgno,
    output logic [1:0]  out_priority
);
    localparam int CW = $clog2(MAX_LAYERS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LAYERS - 1);
    localparam logic [7:0] BACKDROP_ADDR = 8'(BACKDROP_INDEX);

    typedef enum logic [1:0] {COLLECT, READ, CAPTURE, DONE} state_t;

    state_t        state;
    logic [CW-1:0] layer_cnt;
    logic          win_valid;
    logic          win_bitmap;
    logic [1:0]    win_prio;
    logic [14:0]   win_payload;

    logic        accept;
    logic        is_last;
    logic        take;
    logic        nxt_valid;
    logic        nxt_bitmap;
    logic [1:0]  nxt_prio;
    logic [14:0] nxt_payload;
    logic        unused;

    assign px_ready = (state == COLLECT);
    assign accept   = px_valid & px_ready;
    assign is_last  = px_last | (layer_cnt == LAST_CNT);
    assign unused   = px_data[17];

    // Strict less-than keeps the earlier word on a priority tie.
    assign take        = px_data[15] & (~win_valid | (px_data[19:18] < win_prio));
    assign nxt_valid   = take | win_valid;
    assign nxt_bitmap  = take ? px_data[16]    : win_bitmap;
    assign nxt_prio    = take ? px_data[19:18] : win_prio;
    assign nxt_payload = take ? px_data[14:0]  : win_payload;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= COLLECT;
            layer_cnt    <= '0;
            win_valid    <= 1'b0;
            win_bitmap   <= 1'b0;
            win_prio     <= 2'd0;
            win_payload  <= 15'd0;
            pal_re       <= 1'b0;
            pal_addr     <= 8'd0;
            out_valid    <= 1'b0;
            out_color    <= 15'd0;
            out_bgno     <= 3'd4;
            out_priority <= 2'd3;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        win_valid   <= nxt_valid;
                        win_bitmap  <= nxt_bitmap;
                        win_prio    <= nxt_prio;
                        win_payload <= nxt_payload;
                        if (is_last) begin
                            layer_cnt <= '0;
                            if (nxt_valid && nxt_bitmap) begin
                                state        <= DONE;
                                out_valid    <= 1'b1;
                                out_color    <= nxt_payload;
                                out_bgno     <= 3'd2;
                                out_priority <= nxt_prio;
                            end else if (nxt_valid) begin
                                state        <= READ;
                                pal_re       <= 1'b1;
                                pal_addr     <= nxt_payload[7:0];
                                out_bgno     <= {1'b0, nxt_payload[10:9]};
                                out_priority <= nxt_prio;
                            end else begin
                                state        <= READ;
                                pal_re       <= 1'b1;
                                pal_addr     <= BACKDROP_ADDR;
                                out_bgno     <= 3'd4;
                                out_priority <= 2'd3;
                            end
                        end else begin
                            layer_cnt <= layer_cnt + CW'(1);
                        end
                    end
                end
                READ: begin
                    pal_re <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    out_color <= pal_rdata;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        win_valid <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_bg_pixel_resolver.sv
// Bench for bg_pixel_resolver: directed scenarios plus random pixels checked
// against a frontmost-visible-layer reference model and a palette RAM model.
module tb_bg_pixel_resolver;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        px_valid = 1'b0;
    logic        px_ready;
    logic [19:0] px_data = 20'd0;
    logic        px_last = 1'b0;
    logic        pal_re;
    logic [7:0]  pal_addr;
    logic [14:0] pal_rdata = 15'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [14:0] out_color;
    logic [2:0]  out_bgno;
    logic [1:0]  out_priority;

    bg_pixel_resolver #(.MAX_LAYERS(4), .BACKDROP_INDEX(0)) dut (
        .clock(clock), .reset_n(reset_n),
        .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data), .px_last(px_last),
        .pal_re(pal_re), .pal_addr(pal_addr), .pal_rdata(pal_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_color(out_color),
        .out_bgno(out_bgno), .out_priority(out_priority)
    );

    always #5 clock = ~clock;

    logic [14:0] pal_mem [256];
    always @(posedge clock) if (pal_re) pal_rdata <= pal_mem[pal_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [19:0] words [4];

    function automatic logic [19:0] char_word(input logic [1:0] prio, input logic vis,
                                              input logic [1:0] bg, input logic [7:0] idx);
        return {prio, 1'b0, 1'b0, vis, 4'b0000, bg, 1'b0, idx};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Frontmost = lowest priority value among visible words, earliest on ties.
    task automatic model(input int n, output logic [14:0] c, output logic [2:0] bg,
                         output logic [1:0] pr, output int lat, output int nre,
                         output logic [7:0] addr);
        int w;
        w = -1;
        for (int i = 0; i < n; i++)
            if (words[i][15] && (w < 0 || words[i][19:18] < words[w][19:18])) w = i;
        if (w < 0) begin
            addr = 8'd0; c = pal_mem[0]; bg = 3'd4; pr = 2'd3; lat = 3; nre = 1;
        end else if (words[w][16]) begin
            addr = 8'd0; c = words[w][14:0]; bg = 3'd2; pr = words[w][19:18]; lat = 1; nre = 0;
        end else begin
            addr = words[w][7:0]; c = pal_mem[addr]; bg = {1'b0, words[w][10:9]};
            pr = words[w][19:18]; lat = 3; nre = 1;
        end
    endtask

    task automatic check_reset_values(input string name);
        total++;
        if (px_ready !== 1'b1 || pal_re !== 1'b0 || pal_addr !== 8'd0 || out_valid !== 1'b0 ||
            out_color !== 15'd0 || out_bgno !== 3'd4 || out_priority !== 2'd3) begin
            bad++;
            $display("FAIL %s: got rdy=%b re=%b addr=%h ov=%b col=%h bg=%0d pr=%0d want 1 0 00 0 0000 4 3",
                     name, px_ready, pal_re, pal_addr, out_valid, out_color, out_bgno, out_priority);
        end
    endtask

    // Sends words[0..n-1], waits for the result and completes the handshake (out_ready = 1).
    task automatic run_pixel(input int n, input bit use_last, input string name);
        logic [14:0] ec; logic [2:0] eb; logic [1:0] ep; logic [7:0] ea, got_addr;
        int lat, nre, k, re_cnt;
        model(n, ec, eb, ep, lat, nre, ea);
        for (int i = 0; i < n; i++) begin
            px_valid = 1'b1;
            px_data  = words[i];
            px_last  = use_last && (i == n - 1);
            total++;
            if (px_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s px_ready word %0d: got %b want 1", name, i, px_ready);
            end
            step();
        end
        px_valid = 1'b0;
        px_last  = 1'b0;
        px_data  = 20'($urandom);
        k = 1; re_cnt = 0; got_addr = 8'd0;
        while (1) begin
            if (pal_re === 1'b1) begin re_cnt++; got_addr = pal_addr; end
            if (out_valid === 1'b1 || k >= 8) break;
            step();
            k++;
        end
        total++;
        if (k !== lat || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, k, out_valid, lat);
        end
        total++;
        if (out_color !== ec || out_bgno !== eb || out_priority !== ep) begin
            bad++;
            $display("FAIL %s result: got col=%h bg=%0d pr=%0d want col=%h bg=%0d pr=%0d",
                     name, out_color, out_bgno, out_priority, ec, eb, ep);
        end
        total++;
        if (re_cnt !== nre || (nre == 1 && got_addr !== ea)) begin
            bad++;
            $display("FAIL %s palette read: got count=%0d addr=%h want count=%0d addr=%h",
                     name, re_cnt, got_addr, nre, ea);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || px_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s handshake: got ov=%b rdy=%b want 0 1", name, out_valid, px_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(); step();
        check_reset_values("reset");
        reset_n = 1'b1;
        step();
        check_reset_values("after release");
    endtask

    task automatic test_char_pixel();
        pal_mem[8'h22] = 15'h7C1F;
        words[0] = char_word(2'd2, 1'b1, 2'd0, 8'h11);
        words[1] = char_word(2'd1, 1'b1, 2'd1, 8'h22);
        words[2] = char_word(2'd1, 1'b1, 2'd2, 8'h33);
        words[3] = char_word(2'd3, 1'b1, 2'd3, 8'h44);
        run_pixel(4, 1'b1, "char4");
    endtask

    task automatic test_invisible();
        for (int i = 0; i < 4; i++) words[i] = char_word(2'(i), 1'b0, 2'(i), 8'(8'h10 + i));
        run_pixel(4, 1'b1, "invisible");
    endtask

    task automatic test_bitmap();
        words[0] = {2'd0, 1'b0, 1'b1, 1'b1, 15'h03E0};
        run_pixel(1, 1'b1, "bitmap");
        words[0] = char_word(2'd2, 1'b1, 2'd0, 8'h05);
        words[1] = {2'd1, 1'b1, 1'b1, 1'b1, 15'h1234};
        run_pixel(2, 1'b1, "bitmap second");
    endtask

    task automatic test_backpressure();
        logic [14:0] ec; logic [2:0] eb; logic [1:0] ep; logic [7:0] ea;
        int lat, nre, k;
        words[0] = char_word(2'd3, 1'b1, 2'd0, 8'h40);
        words[1] = char_word(2'd1, 1'b1, 2'd1, 8'h41);
        words[2] = char_word(2'd2, 1'b1, 2'd2, 8'h42);
        model(3, ec, eb, ep, lat, nre, ea);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            px_valid = 1'b1; px_data = words[i]; px_last = (i == 2);
            step();
        end
        px_valid = 1'b0; px_last = 1'b0;
        k = 1;
        while (out_valid !== 1'b1 && k < 8) begin step(); k++; end
        // Producer presents a would-be winner while the resolver is busy.
        px_valid = 1'b1; px_data = char_word(2'd0, 1'b1, 2'd3, 8'h99); px_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_color !== ec || out_bgno !== eb ||
                out_priority !== ep || px_ready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure hold %0d: got ov=%b col=%h bg=%0d pr=%0d rdy=%b want 1 %h %0d %0d 0",
                         i, out_valid, out_color, out_bgno, out_priority, px_ready, ec, eb, ep);
            end
            step();
        end
        out_ready = 1'b1; px_valid = 1'b0; px_last = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || px_ready !== 1'b1) begin
            bad++;
            $display("FAIL backpressure release: got ov=%b rdy=%b want 0 1", out_valid, px_ready);
        end
        for (int i = 0; i < 4; i++) words[i] = char_word(2'd0, 1'b0, 2'(i), 8'h77);
        run_pixel(4, 1'b1, "after backpressure");
    endtask

    task automatic test_overflow();
        words[0] = char_word(2'd2, 1'b1, 2'd0, 8'h61);
        words[1] = char_word(2'd3, 1'b1, 2'd1, 8'h62);
        words[2] = char_word(2'd2, 1'b0, 2'd2, 8'h63);
        words[3] = char_word(2'd0, 1'b1, 2'd3, 8'h64);
        run_pixel(4, 1'b0, "overflow");
        words[0] = char_word(2'd1, 1'b1, 2'd0, 8'h71);
        words[1] = char_word(2'd0, 1'b1, 2'd1, 8'h72);
        words[2] = char_word(2'd0, 1'b1, 2'd2, 8'h73);
        words[3] = char_word(2'd3, 1'b0, 2'd3, 8'h74);
        run_pixel(4, 1'b0, "overflow next");
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cyc;
        for (int p = 0; p < 3; p++) begin
            words[0] = char_word(2'(p), 1'b1, 2'd0, 8'(8'h80 + p));
            words[1] = char_word(2'd1, 1'b1, 2'd1, 8'(8'h90 + p));
            run_pixel(2, 1'b1, "back to back");
        end
        total++;
        if (cyc - c0 !== 15) begin
            bad++;
            $display("FAIL throughput: got %0d cycles want 15", cyc - c0);
        end
    endtask

    task automatic test_reset_capture();
        words[0] = char_word(2'd0, 1'b1, 2'd0, 8'h55);
        for (int i = 0; i < 2; i++) begin
            px_valid = 1'b1; px_data = words[0]; px_last = (i == 1);
            step();
        end
        px_valid = 1'b0; px_last = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check_reset_values("reset in capture");
        step();
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 2; i++) words[i] = char_word(2'd1, 1'b0, 2'(i), 8'h56);
        run_pixel(2, 1'b1, "fresh after capture reset");
        px_valid = 1'b1; px_data = char_word(2'd0, 1'b1, 2'd0, 8'h57); px_last = 1'b0;
        step(); step();
        px_valid = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        words[0] = char_word(2'd3, 1'b0, 2'd0, 8'h58);
        run_pixel(1, 1'b1, "fresh after collect reset");
    endtask

    task automatic test_random();
        int n;
        bit use_last;
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(1, 4);
            use_last = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) words[i] = 20'($urandom);
            run_pixel(n, use_last, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) pal_mem[i] = 15'($urandom);
        test_reset();
        test_char_pixel();
        test_invisible();
        test_bitmap();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_capture();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
